tcp_rt_timer: RTL

//  Per-flow TCP retransmit timer table. Consumes arm/disarm events: the TX path arms a flow when it sends

---
 rtl/tcp_pkg.sv | 24 ++
 rtl/tcp_rt_timer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tcp_pkg.sv
// Shared TCP offload types and constants: flow/timestamp widths, per-flow ACK timer entry,
// and the retransmit-timer scanner state encoding and backoff limit.
package tcp_pkg;

    localparam int TIMESTAMP_W       = 32;
    localparam int FLOWID_W          = 8;
    localparam int MAX_TCP_FLOWS     = 256;
    localparam int RT_TIMEOUT_CYCLES = 250_000_000;

    typedef struct packed {
        logic                   armed;
        logic [TIMESTAMP_W-1:0] timestamp;
    } tx_ack_timer_struct;

    typedef enum logic {
        SCAN,
        FIRE
    } rt_timer_state_e;

    // Backoff shift saturates here; BO_W must hold 0..RT_MAX_BACKOFF.
    localparam int RT_MAX_BACKOFF = 3;
    localparam int BO_W           = 2;

endpackage

// File: rtl/tcp_rt_timer.sv
// Per-flow retransmit timer table with a round-robin expiry scanner and one outstanding rt_req.
// Optional per-flow exponential backoff is built when TCP_RT_BACKOFF_EN is defined.
module tcp_rt_timer
    import tcp_pkg::*;
#(
    parameter int unsigned NUM_FLOWS      = MAX_TCP_FLOWS,
    parameter int unsigned TIMEOUT_CYCLES = RT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm_req_val,
    input  logic [FLOWID_W-1:0] arm_req_flowid,
    output logic                arm_req_rdy,
    input  logic                disarm_req_val,
    input  logic [FLOWID_W-1:0] disarm_req_flowid,
    output logic                disarm_req_rdy,
    output logic                rt_req_val,
    output logic [FLOWID_W-1:0] rt_req_flowid,
    input  logic                rt_req_rdy
);

    localparam int PTR_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
    localparam int THR_W = TIMESTAMP_W + RT_MAX_BACKOFF;

    tx_ack_timer_struct     table_reg [NUM_FLOWS];
    logic [TIMESTAMP_W-1:0] now_reg;
    rt_timer_state_e        state_reg, state_next;
    logic [PTR_W-1:0]       scan_ptr_reg, scan_ptr_next, scan_ptr_inc;
    logic                   rt_val_reg, rt_val_next;
    logic [FLOWID_W-1:0]    rt_flowid_reg, rt_flowid_next;
    logic                   fire_now, scan_expired, scan_arm_hit;
    logic [BO_W-1:0]        scan_bo;
    logic [NUM_FLOWS-1:0]   arm_hit, disarm_hit, fire_hit;

    // Modulo subtraction keeps the elapsed time correct across a wrap of now.
    function automatic logic is_expired(input tx_ack_timer_struct e,
                                        input logic [TIMESTAMP_W-1:0] t,
                                        input logic [BO_W-1:0] bo);
        logic [TIMESTAMP_W-1:0] elapsed;
        logic [THR_W-1:0]       thr;
        elapsed = t - e.timestamp;
        thr     = THR_W'(TIMEOUT_CYCLES) << bo;
        return e.armed && ({{RT_MAX_BACKOFF{1'b0}}, elapsed} >= thr);
    endfunction

    assign arm_req_rdy    = 1'b1;
    assign disarm_req_rdy = 1'b1;
    assign rt_req_val     = rt_val_reg;
    assign rt_req_flowid  = rt_flowid_reg;

    // Out-of-range flow ids match no entry and are therefore ignored.
    for (genvar gi = 0; gi < NUM_FLOWS; gi++) begin : g_hit
        assign arm_hit[gi]    = arm_req_val && (arm_req_flowid == FLOWID_W'(gi));
        assign disarm_hit[gi] = disarm_req_val && (disarm_req_flowid == FLOWID_W'(gi));
        assign fire_hit[gi]   = fire_now && (scan_ptr_reg == PTR_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) table_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (arm_hit[i]) begin
                    table_reg[i].armed     <= 1'b1;
                    table_reg[i].timestamp <= now_reg;
                end else if (disarm_hit[i] || fire_hit[i]) begin
                    table_reg[i].armed <= 1'b0;
                end
            end
        end
    end

`ifdef TCP_RT_BACKOFF_EN
    logic [BO_W-1:0] bo_reg [NUM_FLOWS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) bo_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (disarm_hit[i] && !arm_hit[i]) begin
                    bo_reg[i] <= '0;
                end else if (fire_hit[i] && bo_reg[i] != BO_W'(RT_MAX_BACKOFF)) begin
                    bo_reg[i] <= bo_reg[i] + BO_W'(1);
                end
            end
        end
    end

    assign scan_bo = bo_reg[scan_ptr_reg];
`else
    assign scan_bo = '0;
`endif

    assign scan_expired = is_expired(table_reg[scan_ptr_reg], now_reg, scan_bo);
    assign scan_arm_hit = arm_req_val && (arm_req_flowid == FLOWID_W'(scan_ptr_reg));
    assign scan_ptr_inc = (scan_ptr_reg == PTR_W'(NUM_FLOWS - 1)) ? '0 : scan_ptr_reg + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SCAN;
            scan_ptr_reg  <= '0;
            rt_val_reg    <= 1'b0;
            rt_flowid_reg <= '0;
            now_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            scan_ptr_reg  <= scan_ptr_next;
            rt_val_reg    <= rt_val_next;
            rt_flowid_reg <= rt_flowid_next;
            now_reg       <= now_reg + TIMESTAMP_W'(1);
        end
    end

    // A same-cycle arm of the scanned flow wins over its expiry: the entry is rearmed instead.
    always_comb begin
        state_next     = state_reg;
        scan_ptr_next  = scan_ptr_reg;
        rt_val_next    = rt_val_reg;
        rt_flowid_next = rt_flowid_reg;
        fire_now       = 1'b0;
        case (state_reg)
            SCAN: begin
                if (scan_expired && !scan_arm_hit) begin
                    fire_now       = 1'b1;
                    rt_flowid_next = FLOWID_W'(scan_ptr_reg);
                    rt_val_next    = 1'b1;
                    state_next     = FIRE;
                end else begin
                    scan_ptr_next = scan_ptr_inc;
                end
            end
            FIRE: begin
                if (rt_req_rdy) begin
                    rt_val_next   = 1'b0;
                    scan_ptr_next = scan_ptr_inc;
                    state_next    = SCAN;
                end
            end
            default: state_next = SCAN;
        endcase
    end

endmodule
